// File: rtl/sequenciador_xy.sv
`default_nettype none
// ============================================================================
// Module   : sequenciador_xy
// Brief    : Command sequencer driving load/clear strobes for X, Y and R and
//            the ALU operation select. Optional SEQUENCIADOR_CMD_COUNT_EN adds
//            an 8-bit completed-command counter output.
// Revision : 1.0 - initial release
// ============================================================================
module sequenciador_xy #(
    parameter int DATA_W  = 8,
    parameter int ULA_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] valor,
    output logic              load_x,
    output logic              load_y,
    output logic              load_r,
    output logic              clear_regs,
    output logic [1:0]        ula_op,
    output logic              done
`ifdef SEQUENCIADOR_CMD_COUNT_EN
    ,
    output logic [7:0]        cmd_count
`endif
);

    localparam logic [1:0] OP_LOAD_X = 2'b00;
    localparam logic [1:0] OP_LOAD_Y = 2'b01;
    localparam logic [1:0] OP_EXEC   = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [3:0] LAT_INIT = 4'(ULA_LAT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        WAIT_ULA = 3'd2,
        WRITE    = 3'd3,
        CLEAR    = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        lat_cnt;
    logic              accept;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= 2'b00;
            data_q  <= '0;
            lat_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q    <= cmd_op;
                data_q  <= cmd_data;
                lat_cnt <= LAT_INIT;
            end else if (state == WAIT_ULA && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
        end
    end

    // Outputs decode purely from state and the captured command, so input
    // changes after acceptance never reach the register strobes.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        valor      = '0;
        load_x     = 1'b0;
        load_y     = 1'b0;
        load_r     = 1'b0;
        clear_regs = 1'b0;
        ula_op     = 2'b00;
        done       = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = !reset;
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD_X: state_next = LOAD;
                        OP_LOAD_Y: state_next = LOAD;
                        OP_EXEC:   state_next = WAIT_ULA;
                        OP_CLEAR:  state_next = CLEAR;
                        default:   state_next = IDLE;
                    endcase
                end
            end
            LOAD: begin
                valor      = data_q;
                load_x     = (op_q == OP_LOAD_X);
                load_y     = (op_q == OP_LOAD_Y);
                state_next = DONE;
            end
            WAIT_ULA: begin
                ula_op = data_q[1:0];
                if (lat_cnt == 4'd0) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                ula_op     = data_q[1:0];
                load_r     = 1'b1;
                state_next = DONE;
            end
            CLEAR: begin
                clear_regs = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef SEQUENCIADOR_CMD_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_count <= 8'd0;
        end else if (state == DONE) begin
            cmd_count <= cmd_count + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire
